// File: rtl/aes_dr_pkg.sv
// rtl/aes_dr_pkg.sv - shared constants, phase/state codes and GF(2^8) helpers for dual-rail SubBytes
package aes_dr_pkg;

    localparam int BYTE = 8;

    localparam logic [1:0] PH_PRE  = 2'b00;
    localparam logic [1:0] PH_EVAL = 2'b01;
    localparam logic [1:0] PH_IDLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // A byte is a legal dual-rail codeword when every rail pair is complementary
    function automatic logic dr_codeword_ok(input logic [BYTE-1:0] t, input logic [BYTE-1:0] f);
        return &(t ^ f);
    endfunction

    // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box: inverse as a^254 (0 maps to 0), then the affine map with constant 0x63
    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/sbox8b_dr_lane.sv
// rtl/sbox8b_dr_lane.sv - one dual-rail 8-bit S-box lane with phase gating and SBOX_LAT-deep pipeline
module sbox8b_dr_lane #(
    parameter int SBOX_LAT = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] phase,
    input  logic [7:0] in_t,
    input  logic [7:0] in_f,
    output logic [7:0] out_t,
    output logic [7:0] out_f
);
    import aes_dr_pkg::*;

    logic [7:0] eval_t;
    logic [7:0] eval_f;

    // Only a complete codeword in the evaluate phase produces data; everything else stays spacer
    always_comb begin
        eval_t = '0;
        eval_f = '0;
        if (phase == PH_EVAL && dr_codeword_ok(in_t, in_f)) begin
            eval_t = sbox_fwd(in_t);
            eval_f = ~eval_t;
        end
    end

    // The combinational S-box counts as the first stage; the remaining SBOX_LAT-1 stages are flops
    if (SBOX_LAT <= 1) begin : g_comb
        assign out_t = eval_t;
        assign out_f = eval_f;
    end else begin : g_pipe
        logic [7:0] pipe_t_q [SBOX_LAT-1];
        logic [7:0] pipe_f_q [SBOX_LAT-1];
        logic [7:0] pipe_t_d [SBOX_LAT-1];
        logic [7:0] pipe_f_d [SBOX_LAT-1];

        // Shift the evaluated rails down the pipe
        always_comb begin
            pipe_t_d[0] = eval_t;
            pipe_f_d[0] = eval_f;
            for (int i = 1; i < SBOX_LAT - 1; i++) begin
                pipe_t_d[i] = pipe_t_q[i-1];
                pipe_f_d[i] = pipe_f_q[i-1];
            end
        end

        // Pipeline registers, cleared to spacer on reset
        always_ff @(posedge clk) begin
            if (!resetn) begin
                for (int i = 0; i < SBOX_LAT - 1; i++) begin
                    pipe_t_q[i] <= '0;
                    pipe_f_q[i] <= '0;
                end
            end else begin
                pipe_t_q <= pipe_t_d;
                pipe_f_q <= pipe_f_d;
            end
        end

        assign out_t = pipe_t_q[SBOX_LAT-2];
        assign out_f = pipe_f_q[SBOX_LAT-2];
    end

endmodule

// File: rtl/subbytes_dr_lanes.sv
// rtl/subbytes_dr_lanes.sv - dual-rail SubBytes reusing LANES S-boxes over N/(LANES*BYTE) slices
module subbytes_dr_lanes #(
    parameter int N        = 128,
    parameter int BYTE     = 8,
    parameter int LANES    = 4,
    parameter int SBOX_LAT = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         In_Valid,
    output logic         In_Ready,
    input  logic [N-1:0] SubBytes_In_T,
    input  logic [N-1:0] SubBytes_In_F,
    output logic         Out_Valid,
    input  logic         Out_Ready,
    output logic [N-1:0] SubBytes_Out_T,
    output logic [N-1:0] SubBytes_Out_F,
    output logic         Busy,
    output logic         Alarm
);
    import aes_dr_pkg::*;

    localparam int SW     = LANES * BYTE;
    localparam int SLICES = N / SW;
    localparam int NBYTES = N / BYTE;
    localparam int SL_W   = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int EV_W   = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;

    if (BYTE != 8 || LANES < 1 || LANES > N / BYTE || SBOX_LAT < 1 || (N % SW) != 0) begin : g_param_check
        $error("subbytes_dr_lanes: illegal N/BYTE/LANES/SBOX_LAT combination");
    end

    state_e          state_q, state_d;
    logic [SL_W-1:0] slice_q, slice_d;
    logic [EV_W-1:0] eval_q, eval_d;
    logic [N-1:0]    in_t_q, in_t_d, in_f_q, in_f_d;
    logic [N-1:0]    res_t_q, res_t_d, res_f_q, res_f_d;
    logic            alarm_q, alarm_d;
    logic            in_ok;
    logic            last_eval;
    logic [1:0]      lane_phase;
    logic [SW-1:0]   lane_in_t, lane_in_f, lane_out_t, lane_out_f;

    // Codeword check over every byte of the live input rails
    always_comb begin
        in_ok = 1'b1;
        for (int b = 0; b < NBYTES; b++) begin
            in_ok = in_ok & dr_codeword_ok(SubBytes_In_T[b*BYTE +: BYTE], SubBytes_In_F[b*BYTE +: BYTE]);
        end
    end

    assign last_eval = (eval_q == EV_W'(SBOX_LAT - 1));

    // State register: FSM, counters, captured input, result and sticky alarm
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            slice_q <= '0;
            eval_q  <= '0;
            in_t_q  <= '0;
            in_f_q  <= '0;
            res_t_q <= '0;
            res_f_q <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slice_q <= slice_d;
            eval_q  <= eval_d;
            in_t_q  <= in_t_d;
            in_f_q  <= in_f_d;
            res_t_q <= res_t_d;
            res_f_q <= res_f_d;
            alarm_q <= alarm_d;
        end
    end

    // Next state: accept or drop at IDLE, precharge/evaluate per slice, clear everything on output handshake
    always_comb begin
        state_d = state_q;
        slice_d = slice_q;
        eval_d  = eval_q;
        in_t_d  = in_t_q;
        in_f_d  = in_f_q;
        res_t_d = res_t_q;
        res_f_d = res_f_q;
        alarm_d = alarm_q;
        case (state_q)
            ST_IDLE: begin
                if (In_Valid) begin
                    if (in_ok) begin
                        state_d = ST_PRE;
                        slice_d = '0;
                        eval_d  = '0;
                        in_t_d  = SubBytes_In_T;
                        in_f_d  = SubBytes_In_F;
                    end else begin
                        alarm_d = 1'b1;
                    end
                end
            end
            ST_PRE: begin
                state_d = ST_EVAL;
                eval_d  = '0;
            end
            ST_EVAL: begin
                if (last_eval) begin
                    res_t_d[int'(slice_q)*SW +: SW] = lane_out_t;
                    res_f_d[int'(slice_q)*SW +: SW] = lane_out_f;
                    eval_d = '0;
                    if (slice_q == SL_W'(SLICES - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        slice_d = slice_q + 1'b1;
                        state_d = ST_PRE;
                    end
                end else begin
                    eval_d = eval_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (Out_Ready) begin
                    state_d = ST_IDLE;
                    slice_d = '0;
                    in_t_d  = '0;
                    in_f_d  = '0;
                    res_t_d = '0;
                    res_f_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: handshakes, spacer-gated result, lane phase and slice mux
    always_comb begin
        In_Ready       = (state_q == ST_IDLE) && Reset;
        Busy           = (state_q != ST_IDLE);
        Out_Valid      = (state_q == ST_DONE);
        SubBytes_Out_T = (state_q == ST_DONE) ? res_t_q : '0;
        SubBytes_Out_F = (state_q == ST_DONE) ? res_f_q : '0;
        Alarm          = alarm_q;
        lane_phase     = PH_IDLE;
        lane_in_t      = '0;
        lane_in_f      = '0;
        if (state_q == ST_PRE) begin
            lane_phase = PH_PRE;
        end else if (state_q == ST_EVAL) begin
            lane_phase = PH_EVAL;
            lane_in_t  = in_t_q[int'(slice_q)*SW +: SW];
            lane_in_f  = in_f_q[int'(slice_q)*SW +: SW];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sbox8b_dr_lane #(
            .SBOX_LAT(SBOX_LAT)
        ) u_lane (
            .clk   (Clk),
            .resetn(Reset),
            .phase (lane_phase),
            .in_t  (lane_in_t[l*BYTE +: BYTE]),
            .in_f  (lane_in_f[l*BYTE +: BYTE]),
            .out_t (lane_out_t[l*BYTE +: BYTE]),
            .out_f (lane_out_f[l*BYTE +: BYTE])
        );
    end

endmodule

// File: tb/tb_subbytes_dr_lanes.sv
// tb/tb_subbytes_dr_lanes.sv - self-checking bench for subbytes_dr_lanes (default and 16-lane configs)
module tb_subbytes_dr_lanes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn;
    logic         iv1, ir1, ov1, or1, busy1, al1;
    logic [127:0] it1, if1, ot1, of1;
    logic         iv2, ir2, ov2, or2, busy2, al2;
    logic [127:0] it2, if2, ot2, of2;

    subbytes_dr_lanes #(.N(128), .BYTE(8), .LANES(4), .SBOX_LAT(2)) dut1 (
        .Clk(clk), .Reset(rstn), .In_Valid(iv1), .In_Ready(ir1),
        .SubBytes_In_T(it1), .SubBytes_In_F(if1), .Out_Valid(ov1), .Out_Ready(or1),
        .SubBytes_Out_T(ot1), .SubBytes_Out_F(of1), .Busy(busy1), .Alarm(al1)
    );

    subbytes_dr_lanes #(.N(128), .BYTE(8), .LANES(16), .SBOX_LAT(1)) dut2 (
        .Clk(clk), .Reset(rstn), .In_Valid(iv2), .In_Ready(ir2),
        .SubBytes_In_T(it2), .SubBytes_In_F(if2), .Out_Valid(ov2), .Out_Ready(or2),
        .SubBytes_Out_T(ot2), .SubBytes_Out_F(of2), .Busy(busy2), .Alarm(al2)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] ref_tab [256];

    localparam logic [127:0] SB63  = {16{8'h63}};
    localparam logic [127:0] VEC_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] EXP_A = 128'h638293c31bfc33f5c4eeacea4bc12816;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, aa;
        r  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ aa;
            aa = xtime(aa);
        end
        return r;
    endfunction

    // Inverse by exhaustive search, then the bitwise affine transform
    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv, s, c;
        inv = 8'h00;
        c   = 8'h63;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        end
        return s;
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] t);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[b*8 +: 8] = ref_tab[t[b*8 +: 8]];
        return r;
    endfunction

    task automatic send(input int which, input logic [127:0] t, input logic [127:0] f);
        int n;
        n = 0;
        while (((which == 1) ? !ir1 : !ir2) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready", (which == 1) ? ir1 : ir2, 1'b1);
        if (which == 1) begin iv1 = 1'b1; it1 = t; if1 = f; end
        else            begin iv2 = 1'b1; it2 = t; if2 = f; end
        @(posedge clk); #1;
        iv1 = 1'b0; it1 = '0; if1 = '0;
        iv2 = 1'b0; it2 = '0; if2 = '0;
    endtask

    // Counts edges from the accept edge inclusive; probes dut2 lane inputs in every PRE cycle
    task automatic wait_ov(input int which, output int cyc, output int pre_seen);
        cyc = 1;
        pre_seen = 0;
        while (((which == 1) ? !ov1 : !ov2) && cyc < 100) begin
            if (which == 2 && dut2.lane_phase == 2'b00) begin
                pre_seen++;
                check("pre_lane_t", dut2.lane_in_t, '0);
                check("pre_lane_f", dut2.lane_in_f, '0);
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic handshake(input int which);
        if (which == 1) or1 = 1'b1; else or2 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
        or2 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, pre, seen;
        logic [127:0] bt, bf, v;

        for (int i = 0; i < 256; i++) ref_tab[i] = ref_sbox(8'(i));

        rstn = 1'b0;
        iv1 = 1'b1; it1 = '0; if1 = '1; or1 = 1'b0;
        iv2 = 1'b0; it2 = '0; if2 = '0; or2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", ir1, 1'b0);
        check("rst_out_valid", ov1, 1'b0);
        check("rst_out_t", ot1, '0);
        check("rst_out_f", of1, '0);
        check("rst_busy", busy1, 1'b0);
        check("rst_alarm", al1, 1'b0);
        check("rst_in_ready2", ir2, 1'b0);
        iv1 = 1'b0;
        rstn = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", ir1, 1'b1);

        // Zero state: latency and 0x63 everywhere
        send(1, '0, '1);
        check("acc_busy", busy1, 1'b1);
        wait_ov(1, cyc, pre);
        check("lat13", 128'(cyc), 128'd13);
        check("zero_t", ot1, SB63);
        check("zero_f", of1, ~SB63);

        // Back-pressure: result held, not ready for input
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("hold_valid", ov1, 1'b1);
            check("hold_t", ot1, SB63);
            check("hold_f", of1, ~SB63);
            check("hold_in_ready", ir1, 1'b0);
        end
        or1 = 1'b1; iv1 = 1'b1; it1 = VEC_A; if1 = ~VEC_A;
        @(posedge clk); #1;
        or1 = 1'b0; iv1 = 1'b0; it1 = '0; if1 = '0;
        check("post_hs_t", ot1, '0);
        check("post_hs_f", of1, '0);
        check("post_hs_valid", ov1, 1'b0);
        check("post_hs_in_ready", ir1, 1'b1);
        check("post_hs_busy", busy1, 1'b0);

        // Directed byte ramp
        send(1, VEC_A, ~VEC_A);
        wait_ov(1, cyc, pre);
        check("vec_lat", 128'(cyc), 128'd13);
        check("vec_t", ot1, EXP_A);
        check("vec_f", of1, ~EXP_A);
        handshake(1);

        // Broken codeword at bit 37 (T=F=1)
        bt = '0; bt[37] = 1'b1;
        bf = '1;
        send(1, bt, bf);
        check("bad_alarm", al1, 1'b1);
        check("bad_busy", busy1, 1'b0);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ov1) seen++;
        end
        check("bad_no_valid", 128'(seen), 128'd0);
        send(1, VEC_A, ~VEC_A);
        wait_ov(1, cyc, pre);
        check("after_bad_t", ot1, EXP_A);
        check("after_bad_f", of1, ~EXP_A);
        check("alarm_sticky", al1, 1'b1);
        handshake(1);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        check("alarm_cleared", al1, 1'b0);

        // Reset in the middle of a transaction
        v = 128'h0123456789abcdeffedcba9876543210;
        send(1, v, ~v);
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        check("midrst_t", ot1, '0);
        check("midrst_f", of1, '0);
        check("midrst_valid", ov1, 1'b0);
        check("midrst_busy", busy1, 1'b0);
        rstn = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ov1) seen++;
        end
        check("midrst_no_valid", 128'(seen), 128'd0);
        send(1, v, ~v);
        wait_ov(1, cyc, pre);
        check("midrst_new_t", ot1, ref_sub(v));
        check("midrst_new_f", of1, ~ref_sub(v));
        handshake(1);

        // 16 lanes, single-cycle S-box
        send(2, '0, '1);
        wait_ov(2, cyc, pre);
        check("lat3", 128'(cyc), 128'd3);
        check("pre_seen", 128'(pre), 128'd1);
        check("w16_zero_t", ot2, SB63);
        check("w16_zero_f", of2, ~SB63);
        handshake(2);

        for (int r = 0; r < 1000; r++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            send(2, v, ~v);
            wait_ov(2, cyc, pre);
            check("rnd_t", ot2, ref_sub(v));
            check("rnd_f", of2, ~ref_sub(v));
            handshake(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
